// File: rtl/spi_sram_target_if.sv
// SPI pins plus the local byte-memory port of the serial SRAM emulator.
// The target drives MISO and the memory strobes; the board/bench drives the rest.
interface spi_sram_target_if #(
   parameter int ADDR_BITS = 16
);
   logic                 sck;
   logic                 nss;
   logic                 mosi;
   logic                 miso;
   logic                 miso_oe;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [7:0]           mem_wdata;
   logic                 mem_we;
   logic                 mem_re;
   logic [7:0]           mem_rdata;

   modport slave (
      input  sck, nss, mosi, mem_rdata,
      output miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output sck, nss, mosi, mem_rdata,
      input  miso, miso_oe, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/spi_sram_target.sv
// 23LC512-style serial SRAM target for a bit-banged mode-0 SPI master.
// SCK/nSS/MOSI are oversampled in the clk domain; nothing runs on SCK itself.
module spi_sram_target #(
   parameter int ADDR_BITS = 16,
   parameter int PAGE_BITS = 5
) (
   input logic               clk,
   input logic               rst,
   spi_sram_target_if.slave  bus
);
   typedef enum logic [3:0] {
      IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, STAT_RD, STAT_WR, IGNORE
   } state_t;

   state_t               state;
   logic                 sck_m, sck_s, sck_d;
   logic                 nss_m, nss_s;
   logic                 mosi_m, mosi_s;
   logic                 armed;
   logic                 seen_high;
   logic                 is_read;
   logic                 re_d;
   logic [2:0]           bitcnt;
   logic [7:0]           sh_in;
   logic [7:0]           sh_out;
   logic [7:0]           rd_buf;
   logic [7:0]           addr_hi;
   logic [1:0]           mode;
   logic [7:0]           status;
   logic [7:0]           byte_in;
   logic [15:0]          addr16;
   logic [ADDR_BITS-1:0] next_addr;
   logic                 rise;
   logic                 fall;
   logic                 byte_done;
   logic                 byte_mode;

   // A rise only counts once SCK has been seen low while selected, so a
   // clock already high at the nSS fall cannot clock in a bogus bit.
   assign rise      = sck_s & ~sck_d & armed & ~nss_s & (state != IDLE);
   assign fall      = ~sck_s & sck_d & ~nss_s;
   assign byte_in   = {sh_in[6:0], mosi_s};
   assign byte_done = rise && (bitcnt == 3'd7);
   assign addr16    = {addr_hi, byte_in};
   assign status    = {mode, 6'd0};
   assign byte_mode = (mode == 2'b00) || (mode == 2'b11);

   // Page mode wraps inside the page, sequential wraps the whole space.
   always_comb begin
      next_addr = bus.mem_addr + ADDR_BITS'(1);
      if (mode == 2'b10) begin
         next_addr = bus.mem_addr;
         next_addr[PAGE_BITS-1:0] = bus.mem_addr[PAGE_BITS-1:0] + PAGE_BITS'(1);
      end
   end

   // Synchronizers reset low so a target held selected through reset waits
   // for a genuine deselect/select before it listens again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sck_m         <= 1'b0;
         sck_s         <= 1'b0;
         sck_d         <= 1'b0;
         nss_m         <= 1'b0;
         nss_s         <= 1'b0;
         mosi_m        <= 1'b0;
         mosi_s        <= 1'b0;
         armed         <= 1'b0;
         seen_high     <= 1'b0;
         is_read       <= 1'b0;
         re_d          <= 1'b0;
         bitcnt        <= 3'd0;
         sh_in         <= 8'd0;
         sh_out        <= 8'd0;
         rd_buf        <= 8'd0;
         addr_hi       <= 8'd0;
         mode          <= 2'b01;
         bus.miso      <= 1'b0;
         bus.miso_oe   <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 8'd0;
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;
      end else begin
         sck_m      <= bus.sck;
         sck_s      <= sck_m;
         sck_d      <= sck_s;
         nss_m      <= bus.nss;
         nss_s      <= nss_m;
         mosi_m     <= bus.mosi;
         mosi_s     <= mosi_m;
         bus.mem_we <= 1'b0;
         bus.mem_re <= 1'b0;
         re_d       <= bus.mem_re;
         if (bus.mem_we) begin
            bus.mem_addr <= next_addr;
         end
         if (nss_s) begin
            state       <= IDLE;
            bitcnt      <= 3'd0;
            armed       <= 1'b0;
            seen_high   <= 1'b1;
            bus.miso    <= 1'b0;
            bus.miso_oe <= 1'b0;
         end else begin
            armed <= armed | ~sck_s;
            if (rise) begin
               sh_in  <= byte_in;
               bitcnt <= bitcnt + 3'd1;
            end
            case (state)
               IDLE: begin
                  if (seen_high) begin
                     state <= CMD;
                  end
               end
               CMD: begin
                  if (byte_done) begin
                     case (byte_in)
                        8'h03: begin
                           is_read <= 1'b1;
                           state   <= ADDR_HI;
                        end
                        8'h02: begin
                           is_read <= 1'b0;
                           state   <= ADDR_HI;
                        end
                        8'h05: begin
                           state       <= STAT_RD;
                           sh_out      <= status;
                           bus.miso    <= status[7];
                           bus.miso_oe <= 1'b1;
                        end
                        8'h01:   state <= STAT_WR;
                        default: state <= IGNORE;
                     endcase
                  end
               end
               ADDR_HI: begin
                  if (byte_done) begin
                     addr_hi <= byte_in;
                     state   <= ADDR_LO;
                  end
               end
               ADDR_LO: begin
                  if (byte_done) begin
                     bus.mem_addr <= addr16[ADDR_BITS-1:0];
                     if (is_read) begin
                        bus.mem_re <= 1'b1;
                        state      <= RD_DATA;
                     end else begin
                        state <= WR_DATA;
                     end
                  end
               end
               // Each fetched byte waits in rd_buf and moves into the shifter on
               // the fall that starts the next byte; the very first one goes out
               // immediately because nothing is being shifted yet.
               RD_DATA: begin
                  if (re_d) begin
                     rd_buf <= bus.mem_rdata;
                     if (!bus.miso_oe) begin
                        sh_out      <= bus.mem_rdata;
                        bus.miso    <= bus.mem_rdata[7];
                        bus.miso_oe <= 1'b1;
                     end
                  end
                  if (byte_done) begin
                     if (byte_mode) begin
                        state       <= IGNORE;
                        bus.miso    <= 1'b0;
                        bus.miso_oe <= 1'b0;
                     end else begin
                        bus.mem_addr <= next_addr;
                        bus.mem_re   <= 1'b1;
                     end
                  end else if (fall && bus.miso_oe) begin
                     if (bitcnt == 3'd0) begin
                        sh_out   <= rd_buf;
                        bus.miso <= rd_buf[7];
                     end else begin
                        sh_out   <= {sh_out[6:0], 1'b0};
                        bus.miso <= sh_out[6];
                     end
                  end
               end
               WR_DATA: begin
                  if (byte_done) begin
                     bus.mem_wdata <= byte_in;
                     bus.mem_we    <= 1'b1;
                     if (byte_mode) begin
                        state <= IGNORE;
                     end
                  end
               end
               STAT_RD: begin
                  if (fall) begin
                     if (bitcnt == 3'd0) begin
                        sh_out   <= status;
                        bus.miso <= status[7];
                     end else begin
                        sh_out   <= {sh_out[6:0], 1'b0};
                        bus.miso <= sh_out[6];
                     end
                  end
               end
               STAT_WR: begin
                  if (byte_done) begin
                     mode  <= byte_in[7:6];
                     state <= IGNORE;
                  end
               end
               default: begin
                  bus.miso    <= 1'b0;
                  bus.miso_oe <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
